bellek_hakemi: RTL and testbench
================================

# bellek_hakemi

Single-port memory arbiter that shares one synchronous-read word memory between the processor's instruction-fetch port and its load/store data port. It sits between the `islemci` core and a unified 128-word memory. Each cycle it accepts at most one request and drives the memory. It returns read data one cycle later on the owning port. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
- `ADRES_BIT`, 7, memory word-address width (depth 2^ADRES_BIT words)
- `ACLIK_SINIRI`, 3, maximum consecutive cycles fetch may lose a conflict before it is forced a grant (≥1)

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `g_istek` in 1: fetch read request
- `g_adres` in 32: fetch byte address
- `g_hazir` out 1: fetch request accepted this cycle
- `g_gecerli` out 1: fetch read data valid
- `g_veri` out 32: fetch read data
- `v_istek` in 1: data request
- `v_yaz` in 1: 1 = store, 0 = load
- `v_adres` in 32: data byte address
- `v_yaz_veri` in 32: store data
- `v_hazir` out 1: data request accepted this cycle
- `v_gecerli` out 1: data response (load data or store acknowledge)
- `v_veri` out 32: load data
- `b_en` out 1: memory access enable
- `b_yaz` out 1: memory write enable
- `b_adres` out ADRES_BIT: memory word address
- `b_yaz_veri` out 32: memory write data
- `b_okunan` in 32: memory read data, valid the cycle after `b_en=1, b_yaz=0`

## Operation
- Word address = `adres[ADRES_BIT+1:2]`. Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo the memory size.
- Grant decision is combinational in the request cycle:
  - Only one port requesting: that port is granted.
  - Both requesting: data is granted unless `aclik == ACLIK_SINIRI`, in which case fetch is granted.
  - The granted port sees `hazir=1`, and `b_en/b_yaz/b_adres/b_yaz_veri` are driven from it that cycle.
- `b_yaz = v_yaz` on a data grant and 0 on a fetch grant. `b_en = 0` when idle; `b_adres/b_yaz_veri` are don't-care then.
- `aclik` counter, width clog2(ACLIK_SINIRI+1):
  - increments when fetch requests and loses;
  - clears when fetch is granted or not requesting;
  - saturates at ACLIK_SINIRI.
- `sahip` state register records last cycle's grant: BOS, GETIR, VERI_OKU, VERI_YAZ. Next state is the current-cycle grant, or BOS if no grant.
- Responses in the cycle after a grant:
  - GETIR: `g_gecerli=1`, `g_veri=b_okunan`.
  - VERI_OKU: `v_gecerli=1`, `v_veri=b_okunan`.
  - VERI_YAZ: `v_gecerli=1`; `v_veri` holds its previous value.
- Holding registers capture `b_okunan` at the end of each response cycle. `g_veri/v_veri` hold their last returned value while the port is idle.
- Requesters may issue a new request every cycle. A port whose request is not accepted must hold `istek`/address/data stable until `hazir`.

## Timing
- Read latency: request accepted in cycle t, data valid in cycle t+1. Throughput is 1 access per cycle total.
- Store in cycle t, load of the same address granted in cycle t+1 (either port): returns the new value in t+2.
- `rst` high in any cycle:
  - `g_hazir=v_hazir=g_gecerli=v_gecerli=b_en=b_yaz=0` in that same cycle.
  - At the edge, `sahip=BOS`, `aclik=0`, and data holding registers are cleared to 0.
  - A response due in a reset cycle is dropped. A grant in the cycle before reset still wrote memory if it was a store.
- First cycle after `rst` deasserts: normal arbitration, no responses.
- Reset values: every output is 0.

## Test plan
- Reset: `rst=1` for 2 cycles with both `istek=1` → all outputs 0, no `b_en`. First cycle after release: `v_hazir=1`, `g_hazir=0`.
- Fetch stream, memory preloaded `mem[2]=32'h006283b3`, `mem[3]=32'h406280b3`: `g_adres=0x8` then `0xC` on consecutive cycles → `g_hazir=1` both cycles; `g_veri=32'h006283b3` then `32'h406280b3` one cycle later each, with `g_gecerli=1`.
- Conflict with ACLIK_SINIRI=3: both ports request every cycle for 8 cycles → grant sequence V,V,V,G,V,V,V,G, and `aclik` reaches 3 before each fetch grant.
- Store/load: `v_yaz=1`, `v_adres=0x18`, `v_yaz_veri=32'hFFFFFFE2`, then a load of 0x18 → `v_gecerli` pulses after the store; `v_veri=32'hFFFFFFE2` two cycles after the store grant.
- Wrap/alignment with ADRES_BIT=7: `g_adres=0x203` → `b_adres=0`, `b_en=1`, `b_yaz=0`.
- Reset mid-operation: fetch granted in cycle t, `rst=1` in t+1 → `g_gecerli=0` in t+1 and `g_veri=0` after the edge. A store granted in t-1 is visible in memory afterwards.

Source files
------------

// File: rtl/bellek_hakemi.sv
// Single-port memory arbiter: shares one synchronous-read word memory between
// an instruction-fetch port and a load/store data port, data first, fetch never starved.
module bellek_hakemi #(
  parameter int ADRES_BIT    = 7,
  parameter int ACLIK_SINIRI = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 g_istek,
  input  logic [31:0]          g_adres,
  output logic                 g_hazir,
  output logic                 g_gecerli,
  output logic [31:0]          g_veri,
  input  logic                 v_istek,
  input  logic                 v_yaz,
  input  logic [31:0]          v_adres,
  input  logic [31:0]          v_yaz_veri,
  output logic                 v_hazir,
  output logic                 v_gecerli,
  output logic [31:0]          v_veri,
  output logic                 b_en,
  output logic                 b_yaz,
  output logic [ADRES_BIT-1:0] b_adres,
  output logic [31:0]          b_yaz_veri,
  input  logic [31:0]          b_okunan
);

  localparam int AW = $clog2(ACLIK_SINIRI + 1);
  localparam logic [AW-1:0] SINIR = AW'(ACLIK_SINIRI);

  typedef enum logic [1:0] {BOS, GETIR, VERI_OKU, VERI_YAZ} sahip_t;

  sahip_t          sahip_q, sahip_d;
  logic [AW-1:0]   aclik_q, aclik_d;
  logic [31:0]     g_veri_q, g_veri_d;
  logic [31:0]     v_veri_q, v_veri_d;
  logic            g_izin, v_izin, aclik_dolu;

  // Byte-offset and upper address bits are intentionally dropped.
  logic unused_adres_bitleri;
  assign unused_adres_bitleri = ^{g_adres[31:ADRES_BIT+2], g_adres[1:0],
                                  v_adres[31:ADRES_BIT+2], v_adres[1:0]};

  always_comb begin
    g_izin     = 1'b0;
    v_izin     = 1'b0;
    aclik_dolu = (aclik_q == SINIR);
    if (!rst) begin
      if (v_istek && !(g_istek && aclik_dolu)) begin
        v_izin = 1'b1;
      end else if (g_istek) begin
        g_izin = 1'b1;
      end
    end
  end

  always_comb begin
    b_en       = g_izin | v_izin;
    b_yaz      = v_izin & v_yaz;
    b_adres    = '0;
    b_yaz_veri = '0;
    if (v_izin) begin
      b_adres    = v_adres[ADRES_BIT+1:2];
      b_yaz_veri = v_yaz_veri;
    end else if (g_izin) begin
      b_adres    = g_adres[ADRES_BIT+1:2];
    end
  end

  assign g_hazir = g_izin;
  assign v_hazir = v_izin;

  // Starvation counter only runs while fetch is asking and being refused.
  always_comb begin
    aclik_d = '0;
    if (g_istek && !g_izin) begin
      aclik_d = aclik_dolu ? aclik_q : aclik_q + AW'(1);
    end
  end

  always_comb begin
    sahip_d = BOS;
    if (v_izin) begin
      sahip_d = v_yaz ? VERI_YAZ : VERI_OKU;
    end else if (g_izin) begin
      sahip_d = GETIR;
    end
  end

  // A response falling into a reset cycle is dropped and the held data stays put.
  always_comb begin
    g_gecerli = !rst && (sahip_q == GETIR);
    v_gecerli = !rst && ((sahip_q == VERI_OKU) || (sahip_q == VERI_YAZ));
    g_veri_d  = g_veri_q;
    v_veri_d  = v_veri_q;
    if (g_gecerli) begin
      g_veri_d = b_okunan;
    end
    if (!rst && (sahip_q == VERI_OKU)) begin
      v_veri_d = b_okunan;
    end
    g_veri = g_veri_d;
    v_veri = v_veri_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sahip_q  <= BOS;
      aclik_q  <= '0;
      g_veri_q <= '0;
      v_veri_q <= '0;
    end else begin
      sahip_q  <= sahip_d;
      aclik_q  <= aclik_d;
      g_veri_q <= g_veri_d;
      v_veri_q <= v_veri_d;
    end
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Bench for bellek_hakemi: directed table of test-plan cycles, then randomized
// traffic against a transaction-level model with its own memory image.
module tb_bellek_hakemi;

  localparam int AB    = 7;
  localparam int LIM   = 3;
  localparam int DERIN = 1 << AB;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          g_istek, g_hazir, g_gecerli;
  logic [31:0]   g_adres, g_veri;
  logic          v_istek, v_yaz, v_hazir, v_gecerli;
  logic [31:0]   v_adres, v_yaz_veri, v_veri;
  logic          b_en, b_yaz;
  logic [AB-1:0] b_adres;
  logic [31:0]   b_yaz_veri, b_okunan;

  always #5 clk = ~clk;

  bellek_hakemi #(.ADRES_BIT(AB), .ACLIK_SINIRI(LIM)) dut (
    .clk(clk), .rst(rst),
    .g_istek(g_istek), .g_adres(g_adres), .g_hazir(g_hazir),
    .g_gecerli(g_gecerli), .g_veri(g_veri),
    .v_istek(v_istek), .v_yaz(v_yaz), .v_adres(v_adres), .v_yaz_veri(v_yaz_veri),
    .v_hazir(v_hazir), .v_gecerli(v_gecerli), .v_veri(v_veri),
    .b_en(b_en), .b_yaz(b_yaz), .b_adres(b_adres), .b_yaz_veri(b_yaz_veri),
    .b_okunan(b_okunan)
  );

  // Memory the arbiter drives: synchronous read, one cycle latency.
  logic [31:0] mem [DERIN];
  logic [31:0] okunan_q;
  always @(posedge clk) begin
    if (b_en) begin
      if (b_yaz) mem[b_adres] <= b_yaz_veri;
      else       okunan_q     <= mem[b_adres];
    end
  end
  assign b_okunan = okunan_q;

  int checks = 0;
  int errors = 0;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    checks++;
    if (gercek !== beklenen) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  function automatic logic [31:0] iv(input int i);
    return {8'hA5, i[7:0], 16'(i * 37)};
  endfunction

  function automatic int kelime(input logic [31:0] a);
    return int'((a >> 2) % DERIN);
  endfunction

  // Reference model: pending response kind 0 none, 1 fetch, 2 load, 3 store.
  logic [31:0] ref_mem [DERIN];
  int          m_aclik;
  int          m_bek;
  logic [31:0] m_bek_veri, m_tut_g, m_tut_v;
  bit          m_hazir = 1'b0;
  bit          m_g, m_v;

  task automatic model_kontrol();
    m_g = 1'b0;
    m_v = 1'b0;
    if (!rst && v_istek && !(g_istek && m_aclik == LIM)) m_v = 1'b1;
    else if (!rst && g_istek) m_g = 1'b1;
    kontrol("m_g_hazir", 32'(g_hazir), 32'(m_g));
    kontrol("m_v_hazir", 32'(v_hazir), 32'(m_v));
    kontrol("m_b_en", 32'(b_en), 32'(m_g | m_v));
    kontrol("m_b_yaz", 32'(b_yaz), 32'(m_v & v_yaz));
    if (m_v) kontrol("m_b_adres", 32'(b_adres), 32'(kelime(v_adres)));
    if (m_g) kontrol("m_b_adres", 32'(b_adres), 32'(kelime(g_adres)));
    if (m_v && v_yaz) kontrol("m_b_yaz_veri", b_yaz_veri, v_yaz_veri);
    kontrol("m_g_gecerli", 32'(g_gecerli), 32'(!rst && m_bek == 1));
    kontrol("m_v_gecerli", 32'(v_gecerli), 32'(!rst && m_bek >= 2));
    if (!rst && m_hazir) begin
      kontrol("m_g_veri", g_veri, (m_bek == 1) ? m_bek_veri : m_tut_g);
      kontrol("m_v_veri", v_veri, (m_bek == 2) ? m_bek_veri : m_tut_v);
    end
  endtask

  task automatic model_adim();
    int a;
    if (rst) begin
      m_aclik = 0;
      m_bek   = 0;
      m_tut_g = '0;
      m_tut_v = '0;
      m_hazir = 1'b1;
    end else begin
      if (m_bek == 1) m_tut_g = m_bek_veri;
      if (m_bek == 2) m_tut_v = m_bek_veri;
      if (g_istek && !m_g) m_aclik = (m_aclik < LIM) ? m_aclik + 1 : LIM;
      else m_aclik = 0;
      m_bek = 0;
      if (m_v) begin
        a = kelime(v_adres);
        if (v_yaz) begin
          ref_mem[a] = v_yaz_veri;
          m_bek = 3;
        end else begin
          m_bek = 2;
          m_bek_veri = ref_mem[a];
        end
      end else if (m_g) begin
        m_bek = 1;
        m_bek_veri = ref_mem[kelime(g_adres)];
      end
    end
  endtask

  task automatic sur(input bit r, input bit gi, input logic [31:0] ga,
                     input bit vi, input bit vy, input logic [31:0] va, input logic [31:0] vd);
    rst = r; g_istek = gi; g_adres = ga;
    v_istek = vi; v_yaz = vy; v_adres = va; v_yaz_veri = vd;
  endtask

  typedef struct {
    bit r; bit gi; logic [31:0] ga; bit vi; bit vy; logic [31:0] va; logic [31:0] vd;
    bit e_gh; bit e_vh; bit e_ben; bit e_byaz; int e_badr;
    bit e_gg; bit e_vg; bit chk; logic [31:0] e_gv; logic [31:0] e_vv;
  } satir_t;

  function automatic satir_t mk(input bit r, input bit gi, input logic [31:0] ga,
                                input bit vi, input bit vy, input logic [31:0] va, input logic [31:0] vd,
                                input bit gh, input bit vh, input bit ben, input bit byaz, input int badr,
                                input bit gg, input bit vg, input bit chk,
                                input logic [31:0] gv, input logic [31:0] vv);
    satir_t s;
    s.r = r; s.gi = gi; s.ga = ga; s.vi = vi; s.vy = vy; s.va = va; s.vd = vd;
    s.e_gh = gh; s.e_vh = vh; s.e_ben = ben; s.e_byaz = byaz; s.e_badr = badr;
    s.e_gg = gg; s.e_vg = vg; s.chk = chk; s.e_gv = gv; s.e_vv = vv;
    return s;
  endfunction

  localparam int NSATIR = 26;
  satir_t tab [NSATIR];

  initial begin
    bit          gp, vp, vpy, r;
    logic [31:0] gpa, vpa, vpd;

    for (int i = 0; i < DERIN; i++) begin
      mem[i] = iv(i);
      ref_mem[i] = iv(i);
    end
    mem[2] = 32'h006283b3; ref_mem[2] = 32'h006283b3;
    mem[3] = 32'h406280b3; ref_mem[3] = 32'h406280b3;
    m_aclik = 0; m_bek = 0; m_bek_veri = '0; m_tut_g = '0; m_tut_v = '0;

    //           rst gi ga          vi vy va          vd           gh vh en yz adr gg vg ck g_veri        v_veri
    tab[0]  = mk(H, H, 32'h8,       H, L, 32'h4,      0,           L, L, L, L, 0,  L, L, L, 0,            0);
    tab[1]  = mk(H, H, 32'h8,       H, L, 32'h4,      0,           L, L, L, L, 0,  L, L, L, 0,            0);
    tab[2]  = mk(L, H, 32'h8,       H, L, 32'h4,      0,           L, H, H, L, 1,  L, L, H, 0,            0);
    tab[3]  = mk(L, H, 32'h8,       L, L, 32'h0,      0,           H, L, H, L, 2,  L, H, H, 0,            iv(1));
    tab[4]  = mk(L, H, 32'hC,       L, L, 32'h0,      0,           H, L, H, L, 3,  H, L, H, 32'h006283b3, iv(1));
    tab[5]  = mk(L, L, 32'h0,       L, L, 32'h0,      0,           L, L, L, L, 0,  H, L, H, 32'h406280b3, iv(1));
    tab[6]  = mk(L, L, 32'h0,       L, L, 32'h0,      0,           L, L, L, L, 0,  L, L, H, 32'h406280b3, iv(1));
    tab[7]  = mk(L, H, 32'h10,      H, L, 32'h14,     0,           L, H, H, L, 5,  L, L, H, 32'h406280b3, iv(1));
    tab[8]  = mk(L, H, 32'h10,      H, L, 32'h14,     0,           L, H, H, L, 5,  L, H, H, 32'h406280b3, iv(5));
    tab[9]  = mk(L, H, 32'h10,      H, L, 32'h14,     0,           L, H, H, L, 5,  L, H, H, 32'h406280b3, iv(5));
    tab[10] = mk(L, H, 32'h10,      H, L, 32'h14,     0,           H, L, H, L, 4,  L, H, H, 32'h406280b3, iv(5));
    tab[11] = mk(L, H, 32'h10,      H, L, 32'h14,     0,           L, H, H, L, 5,  H, L, H, iv(4),        iv(5));
    tab[12] = mk(L, H, 32'h10,      H, L, 32'h14,     0,           L, H, H, L, 5,  L, H, H, iv(4),        iv(5));
    tab[13] = mk(L, H, 32'h10,      H, L, 32'h14,     0,           L, H, H, L, 5,  L, H, H, iv(4),        iv(5));
    tab[14] = mk(L, H, 32'h10,      H, L, 32'h14,     0,           H, L, H, L, 4,  L, H, H, iv(4),        iv(5));
    tab[15] = mk(L, L, 32'h0,       H, H, 32'h18,     32'hFFFFFFE2, L, H, H, H, 6, H, L, H, iv(4),        iv(5));
    tab[16] = mk(L, L, 32'h0,       H, L, 32'h18,     0,           L, H, H, L, 6,  L, H, H, iv(4),        iv(5));
    tab[17] = mk(L, L, 32'h0,       L, L, 32'h0,      0,           L, L, L, L, 0,  L, H, H, iv(4),        32'hFFFFFFE2);
    tab[18] = mk(L, H, 32'h203,     L, L, 32'h0,      0,           H, L, H, L, 0,  L, L, H, iv(4),        32'hFFFFFFE2);
    tab[19] = mk(L, L, 32'h0,       L, L, 32'h0,      0,           L, L, L, L, 0,  H, L, H, iv(0),        32'hFFFFFFE2);
    tab[20] = mk(L, L, 32'h0,       H, H, 32'h40,     32'h12345678, L, H, H, H, 16, L, L, H, iv(0),       32'hFFFFFFE2);
    tab[21] = mk(L, H, 32'h40,      L, L, 32'h0,      0,           H, L, H, L, 16, L, H, H, iv(0),        32'hFFFFFFE2);
    tab[22] = mk(H, L, 32'h0,       L, L, 32'h0,      0,           L, L, L, L, 0,  L, L, L, 0,            0);
    tab[23] = mk(L, L, 32'h0,       L, L, 32'h0,      0,           L, L, L, L, 0,  L, L, H, 0,            0);
    tab[24] = mk(L, L, 32'h0,       H, L, 32'h40,     0,           L, H, H, L, 16, L, L, H, 0,            0);
    tab[25] = mk(L, L, 32'h0,       L, L, 32'h0,      0,           L, L, L, L, 0,  L, H, H, 0,            32'h12345678);

    for (int i = 0; i < NSATIR; i++) begin
      sur(tab[i].r, tab[i].gi, tab[i].ga, tab[i].vi, tab[i].vy, tab[i].va, tab[i].vd);
      #4;
      kontrol("g_hazir", 32'(g_hazir), 32'(tab[i].e_gh));
      kontrol("v_hazir", 32'(v_hazir), 32'(tab[i].e_vh));
      kontrol("b_en", 32'(b_en), 32'(tab[i].e_ben));
      kontrol("b_yaz", 32'(b_yaz), 32'(tab[i].e_byaz));
      if (tab[i].e_ben) kontrol("b_adres", 32'(b_adres), 32'(tab[i].e_badr));
      if (tab[i].e_byaz) kontrol("b_yaz_veri", b_yaz_veri, tab[i].vd);
      kontrol("g_gecerli", 32'(g_gecerli), 32'(tab[i].e_gg));
      kontrol("v_gecerli", 32'(v_gecerli), 32'(tab[i].e_vg));
      if (tab[i].chk) begin
        kontrol("g_veri", g_veri, tab[i].e_gv);
        kontrol("v_veri", v_veri, tab[i].e_vv);
      end
      model_kontrol();
      $display("row %0d: rst=%b g_hazir=%b v_hazir=%b b_adres=%0d g_gecerli=%b g_veri=%h v_gecerli=%b v_veri=%h",
               i, rst, g_hazir, v_hazir, b_adres, g_gecerli, g_veri, v_gecerli, v_veri);
      model_adim();
      @(posedge clk);
      #1;
    end

    // Random traffic; a refused request is held until its grant.
    gp = 1'b0; vp = 1'b0; vpy = 1'b0;
    gpa = '0; vpa = '0; vpd = '0;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 39) == 0);
      if (!gp && $urandom_range(0, 9) < 7) begin
        gp = 1'b1;
        gpa = $urandom & 32'h0000_03FF;
      end
      if (!vp && $urandom_range(0, 9) < 6) begin
        vp = 1'b1;
        vpy = $urandom_range(0, 2) == 0;
        vpa = $urandom & 32'h0000_03FF;
        vpd = $urandom;
      end
      sur(r, gp, gpa, vp, vpy, vpa, vpd);
      #4;
      model_kontrol();
      if (m_g || m_v)
        $display("rnd %0d: %s grant word %0d yaz=%b", c, m_v ? "data" : "fetch", b_adres, b_yaz);
      model_adim();
      if (m_g) gp = 1'b0;
      if (m_v) vp = 1'b0;
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
